// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder: SPI mode-0 slave answering the ADXL362 command set
// (0x0A register write, 0x0B register read, address byte, streamed data).
// Acceleration samples arrive on parallel inputs; POWER_CTL drives measure_en_o.
// Optional build macro ADXL362_SHADOW_SNAPSHOT_EN: data registers are copied to
// shadows at cs falling edge so burst reads of 0x0E..0x13 are coherent.
module adxl362_spi_responder #(
  parameter int unsigned p_sync_stages = 2,
  parameter logic [7:0]  p_devid_ad    = 8'hAD,
  parameter logic [7:0]  p_devid_mst   = 8'h1D,
  parameter logic [7:0]  p_partid      = 8'hF2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        sclk_i,
  input  logic        mosi_i,
  output logic        miso_o,
  input  logic [15:0] ax_i,
  input  logic [15:0] ay_i,
  input  logic [15:0] az_i,
  input  logic        sample_load_i,
  output logic        measure_en_o,
  output logic        reg_wr_o,
  output logic [5:0]  reg_addr_o,
  output logic [7:0]  reg_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_RD     = 3'd3,
    S_WR     = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  localparam logic [5:0] c_addr_status = 6'h0B;
  localparam logic [5:0] c_addr_zh     = 6'h13;
  localparam logic [5:0] c_addr_power  = 6'h2D;

  // Synchronizer chains; cs resets low so a frame already in progress at
  // reset release produces no falling edge and is ignored until cs rises.
  logic [p_sync_stages-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic r_cs_d, r_sclk_d;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx;
  logic [7:0]  r_tx;
  logic [5:0]  r_addr;
  logic        r_is_wr;
  logic        r_miso;
  logic [7:0]  r_power_ctl;
  logic        r_measure_en;
  logic        r_reg_wr;
  logic [5:0]  r_reg_addr;
  logic [7:0]  r_reg_wdata;
  logic [15:0] r_xdata, r_ydata, r_zdata;
  logic        r_data_ready;

  logic        w_cs_s, w_sclk_s, w_mosi_s;
  logic        w_cs_fall, w_cs_rise, w_sclk_fall, w_sclk_rise;
  logic [7:0]  w_rx_next;
  logic [7:0]  w_rd_data;
  logic        w_rd_load;
  logic [15:0] w_xrd, w_yrd, w_zrd;

  assign w_cs_s      = r_cs_sync[p_sync_stages-1];
  assign w_sclk_s    = r_sclk_sync[p_sync_stages-1];
  assign w_mosi_s    = r_mosi_sync[p_sync_stages-1];
  assign w_cs_fall   = r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d & w_cs_s;
  assign w_sclk_rise = ~r_sclk_d & w_sclk_s;
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_rx_next   = {r_rx[6:0], w_mosi_s};
  // A read byte is loaded on the first falling edge of each byte slot.
  assign w_rd_load   = (r_state == S_RD) && !w_cs_rise && w_sclk_fall && (r_bit_cnt == 3'd0);

  // Bring cs/sclk/mosi into clk_i domain and keep a delayed copy for edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cs_sync   <= {p_sync_stages{1'b0}};
      r_sclk_sync <= {p_sync_stages{1'b0}};
      r_mosi_sync <= {p_sync_stages{1'b0}};
      r_cs_d      <= 1'b0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[p_sync_stages-2:0], cs_i};
      r_sclk_sync <= {r_sclk_sync[p_sync_stages-2:0], sclk_i};
      r_mosi_sync <= {r_mosi_sync[p_sync_stages-2:0], mosi_i};
      r_cs_d      <= w_cs_s;
      r_sclk_d    <= w_sclk_s;
    end
  end

  // Sample registers and DATA_READY; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xdata      <= 16'h0000;
      r_ydata      <= 16'h0000;
      r_zdata      <= 16'h0000;
      r_data_ready <= 1'b0;
    end else begin
      if (sample_load_i) begin
        r_xdata <= ax_i;
        r_ydata <= ay_i;
        r_zdata <= az_i;
      end
      if (sample_load_i && r_measure_en) begin
        r_data_ready <= 1'b1;
      end else if (w_rd_load && (r_addr == c_addr_zh)) begin
        r_data_ready <= 1'b0;
      end
    end
  end

`ifdef ADXL362_SHADOW_SNAPSHOT_EN
  logic [15:0] r_xshadow, r_yshadow, r_zshadow;

  // Freeze the sample set at frame start so a burst read cannot tear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xshadow <= 16'h0000;
      r_yshadow <= 16'h0000;
      r_zshadow <= 16'h0000;
    end else if (w_cs_fall) begin
      r_xshadow <= r_xdata;
      r_yshadow <= r_ydata;
      r_zshadow <= r_zdata;
    end
  end

  assign w_xrd = r_xshadow;
  assign w_yrd = r_yshadow;
  assign w_zrd = r_zshadow;
`else
  assign w_xrd = r_xdata;
  assign w_yrd = r_ydata;
  assign w_zrd = r_zdata;
`endif

  // Register map read multiplexer addressed by the current auto-increment pointer.
  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      6'h00:         w_rd_data = p_devid_ad;
      6'h01:         w_rd_data = p_devid_mst;
      6'h02:         w_rd_data = p_partid;
      c_addr_status: w_rd_data = {7'd0, r_data_ready};
      6'h0E:         w_rd_data = w_xrd[7:0];
      6'h0F:         w_rd_data = w_xrd[15:8];
      6'h10:         w_rd_data = w_yrd[7:0];
      6'h11:         w_rd_data = w_yrd[15:8];
      6'h12:         w_rd_data = w_zrd[7:0];
      6'h13:         w_rd_data = w_zrd[15:8];
      c_addr_power:  w_rd_data = r_power_ctl;
      default:       w_rd_data = 8'h00;
    endcase
  end

  // Frame FSM: command, address, then streamed read or write bytes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_rx         <= 8'h00;
      r_tx         <= 8'h00;
      r_addr       <= 6'h00;
      r_is_wr      <= 1'b0;
      r_miso       <= 1'b0;
      r_power_ctl  <= 8'h00;
      r_measure_en <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_reg_addr   <= 6'h00;
      r_reg_wdata  <= 8'h00;
    end else begin
      r_reg_wr     <= 1'b0;
      r_measure_en <= (r_power_ctl[1:0] == 2'b10);
      if (w_cs_rise) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
              r_state   <= S_CMD;
              r_bit_cnt <= 3'd0;
            end
          end
          S_CMD: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (w_rx_next == 8'h0B) begin
                  r_is_wr <= 1'b0;
                  r_state <= S_ADDR;
                end else if (w_rx_next == 8'h0A) begin
                  r_is_wr <= 1'b1;
                  r_state <= S_ADDR;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr  <= w_rx_next[5:0];
                r_state <= r_is_wr ? S_WR : S_RD;
              end
            end
          end
          S_RD: begin
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_rd_load) begin
              r_tx   <= w_rd_data;
              r_miso <= w_rd_data[7];
              r_addr <= r_addr + 6'd1;
            end else if (w_sclk_fall) begin
              r_tx   <= {r_tx[6:0], 1'b0};
              r_miso <= r_tx[6];
            end
          end
          S_WR: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_addr == c_addr_power) begin
                  r_power_ctl <= w_rx_next;
                  r_reg_wr    <= 1'b1;
                  r_reg_addr  <= r_addr;
                  r_reg_wdata <= w_rx_next;
                end
                r_addr <= r_addr + 6'd1;
              end
            end
          end
          S_IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso_o       = r_miso;
  assign measure_en_o = r_measure_en;
  assign reg_wr_o     = r_reg_wr;
  assign reg_addr_o   = r_reg_addr;
  assign reg_wdata_o  = r_reg_wdata;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: drives SPI mode-0 frames and
// compares MISO bytes and side-band outputs to hand-computed values.
module tb_adxl362_spi_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cs_i;
  logic        sclk_i;
  logic        mosi_i;
  logic        miso_o;
  logic [15:0] ax_i, ay_i, az_i;
  logic        sample_load_i;
  logic        measure_en_o;
  logic        reg_wr_o;
  logic [5:0]  reg_addr_o;
  logic [7:0]  reg_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int wr_before;
  logic [7:0] r;
  logic [7:0] exp_b [6];

  adxl362_spi_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .sclk_i(sclk_i),
    .mosi_i(mosi_i), .miso_o(miso_o), .ax_i(ax_i), .ay_i(ay_i), .az_i(az_i),
    .sample_load_i(sample_load_i), .measure_en_o(measure_en_o),
    .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  // Count write-commit pulses.
  always @(posedge clk_i) begin
    if (reg_wr_o) wr_count <= wr_count + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi_i = tx[i];
      #80;
      rx[i] = miso_o;
      sclk_i = 1'b1;
      #80;
      sclk_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    cs_i = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #100;
    cs_i = 1'b1;
    #200;
  endtask

  task automatic read1(input logic [7:0] addr, output logic [7:0] rx);
    logic [7:0] d;
    cs_begin();
    spi_byte(8'h0B, d);
    spi_byte(addr, d);
    spi_byte(8'h00, rx);
    cs_end();
  endtask

  task automatic load_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk_i);
    ax_i = x; ay_i = y; az_i = z;
    sample_load_i = 1'b1;
    @(negedge clk_i);
    sample_load_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cs_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0;
    ax_i = 16'h0000; ay_i = 16'h0000; az_i = 16'h0000; sample_load_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check_eq("rst_miso", {31'd0, miso_o}, 32'd0);
    check_eq("rst_meas", {31'd0, measure_en_o}, 32'd0);
    check_eq("rst_wr", {31'd0, reg_wr_o}, 32'd0);
    check_eq("rst_addr", {26'd0, reg_addr_o}, 32'd0);
    check_eq("rst_wdata", {24'd0, reg_wdata_o}, 32'd0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);

    // Identity read with auto-increment
    cs_begin();
    spi_byte(8'h0B, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r); check_eq("id_ad", {24'd0, r}, 32'hAD);
    spi_byte(8'h00, r); check_eq("id_1d", {24'd0, r}, 32'h1D);
    spi_byte(8'h00, r); check_eq("id_f2", {24'd0, r}, 32'hF2);
    cs_end();

    // Measurement enable via POWER_CTL
    wr_before = wr_count;
    cs_begin();
    spi_byte(8'h0A, r);
    spi_byte(8'h2D, r);
    spi_byte(8'h02, r);
    cs_end();
    check_eq("pw_wr_cnt", wr_count - wr_before, 32'd1);
    check_eq("pw_addr", {26'd0, reg_addr_o}, 32'h2D);
    check_eq("pw_wdata", {24'd0, reg_wdata_o}, 32'h02);
    check_eq("pw_meas", {31'd0, measure_en_o}, 32'd1);
    read1(8'h2D, r); check_eq("pw_read", {24'd0, r}, 32'h02);

    // Write to a read-only address raises no pulse
    wr_before = wr_count;
    cs_begin();
    spi_byte(8'h0A, r);
    spi_byte(8'h00, r);
    spi_byte(8'h55, r);
    cs_end();
    check_eq("ro_wr_cnt", wr_count - wr_before, 32'd0);

    // Burst read of sample registers
    load_sample(16'h1234, 16'hFF80, 16'h0001);
    read1(8'h0B, r); check_eq("status_set", {24'd0, r}, 32'h01);
    exp_b = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h01, 8'h00};
    cs_begin();
    spi_byte(8'h0B, r);
    spi_byte(8'h0E, r);
    for (int i = 0; i < 6; i++) begin
      spi_byte(8'h00, r);
      check_eq($sformatf("burst%0d", i), {24'd0, r}, {24'd0, exp_b[i]});
    end
    cs_end();
    read1(8'h0B, r); check_eq("status_clr", {24'd0, r}, 32'h00);

    // Aborted write: cs rises after 4 data bits
    wr_before = wr_count;
    cs_begin();
    spi_byte(8'h0A, r);
    spi_byte(8'h2D, r);
    spi_bits(8'h00, 4, r);
    cs_end();
    check_eq("abort_wr_cnt", wr_count - wr_before, 32'd0);
    check_eq("abort_meas", {31'd0, measure_en_o}, 32'd1);
    read1(8'h2D, r); check_eq("abort_pwr", {24'd0, r}, 32'h02);

    // Unknown command keeps MISO low
    cs_begin();
    spi_byte(8'h55, r); check_eq("unk_b0", {24'd0, r}, 32'h00);
    spi_byte(8'h00, r); check_eq("unk_b1", {24'd0, r}, 32'h00);
    spi_byte(8'hFF, r); check_eq("unk_b2", {24'd0, r}, 32'h00);
    cs_end();

    // Address wrap 0x3F -> 0x00
    cs_begin();
    spi_byte(8'h0B, r);
    spi_byte(8'h3F, r);
    spi_byte(8'h00, r); check_eq("wrap_3f", {24'd0, r}, 32'h00);
    spi_byte(8'h00, r); check_eq("wrap_00", {24'd0, r}, 32'hAD);
    cs_end();

    // Mid-frame sample load during the 4th data byte
`ifdef ADXL362_SHADOW_SNAPSHOT_EN
    exp_b = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h01, 8'h00};
`else
    exp_b = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h77, 8'h77};
`endif
    cs_begin();
    spi_byte(8'h0B, r);
    spi_byte(8'h0E, r);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, r);
      check_eq($sformatf("snap%0d", i), {24'd0, r}, {24'd0, exp_b[i]});
    end
    fork
      spi_byte(8'h00, r);
      begin
        #300;
        load_sample(16'hAAAA, 16'h5555, 16'h7777);
      end
    join
    check_eq("snap3", {24'd0, r}, {24'd0, exp_b[3]});
    for (int i = 4; i < 6; i++) begin
      spi_byte(8'h00, r);
      check_eq($sformatf("snap%0d", i), {24'd0, r}, {24'd0, exp_b[i]});
    end
    cs_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
